rename_reg_file: RTL and testbench
==================================

RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the data width.
REQ-003 The block SHALL have parameter TAG_W, default 6, giving the tag and register-index width.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- q_rs_1, q_rs_2, q_rd  in  TAG_W each  query architectural indices; bits [4:0] are used and bit 5 is ignored.
- q_new_tag  in  TAG_W  tag assigned to q_rd on rename.
- q_rename  in  1  rename strobe.
- q_tag  in  1  query strobe.
- o_rs_1, o_rs_2, o_rd  out  TAG_W each  resolved source tags and the old tag of rd.
- o_new_tag  out  TAG_W  echo of q_new_tag.
- v_src_1, v_src_2  in  TAG_W each  value-read indices; bits [4:0] are used.
- v_data_1, v_data_2  out  XLEN each  register values.
- v_valid_1, v_valid_2  out  1 each  value is committed and not pending.
- wb_valid  in  1  writeback strobe.
- wb_tag  in  TAG_W  writeback tag.
- wb_data  in  XLEN  writeback value.

Function
REQ-005 The block SHALL hold 32 entries, each with value[XLEN], tag[TAG_W] and pending[1].
REQ-006 When q_tag=1, the block SHALL register, one cycle later, each source output as follows: if the entry is pending, output its tag; otherwise output {1'b0, index}.
REQ-007 When q_tag=1, o_rd SHALL carry the rd entry's current tag if pending, else {1'b0, q_rd[4:0]}; o_new_tag SHALL echo q_new_tag.
REQ-008 When q_tag=0, the query outputs SHALL hold their previous values.
REQ-009 When q_rename=1 and q_rd[4:0]!=0, the block SHALL set entry rd to tag=q_new_tag and pending=1 at the clock edge.
REQ-010 A query and a rename in the same cycle SHALL report the pre-rename state; a source equal to rd in that cycle sees the old mapping.
REQ-011 When wb_valid=1, every entry with pending=1 and tag==wb_tag SHALL take value=wb_data and pending=0 at the clock edge.
REQ-012 A rename and a matching writeback to the same entry in the same cycle SHALL resolve with the rename winning: the entry stays pending with the new tag and its value is unchanged.
REQ-013 A writeback whose tag matches no pending entry SHALL be ignored.
REQ-014 Value reads SHALL have one-cycle registered latency: v_data_n = value[v_src_n[4:0]] and v_valid_n = !pending, updated every cycle.
REQ-015 Entry 0 SHALL always read value 0 with valid=1; rename and writeback to x0 SHALL be ignored.
REQ-016 The block SHALL have no state machine beyond the per-entry pending flag.
REQ-017 All outputs SHALL be driven from flops.

Reset
REQ-018 While reset_n=0, every entry SHALL hold value=0, tag=0 and pending=0.
REQ-019 While reset_n=0, all query outputs, v_data_n and v_valid_n SHALL be 0.
REQ-020 Assertion of reset_n mid-operation SHALL discard all pending mappings immediately, without waiting for a clock edge.
REQ-021 After release of reset_n, the first clock edge SHALL produce v_valid_n=1 for any read.

Configuration
REQ-022 With WB_BYPASS_EN defined, a value read whose entry is pending with tag==wb_tag while wb_valid=1 in the same cycle SHALL return wb_data with v_valid=1.
REQ-023 With WB_BYPASS_EN defined, a query source that matches a same-cycle writeback SHALL report {1'b0, index}.
REQ-024 Without WB_BYPASS_EN, same-cycle reads SHALL see the pre-writeback state: the old value with v_valid=0, and the tag on a query.

Verification
REQ-025 Reset, then read v_src_1=5, v_src_2=0 -> v_data_1=0, v_valid_1=1, v_data_2=0, v_valid_2=1.
REQ-026 Rename x3 to tag 40; next cycle query rs_1=3, rd=3 -> o_rs_1=40, o_rd=40; v_src_1=3 -> v_valid_1=0.
REQ-027 With x3 pending on tag 40, apply wb_valid=1, wb_tag=40, wb_data=0xDEADBEEF -> the next read of x3 returns 0xDEADBEEF with valid=1, and a query returns o_rs_1=3.
REQ-028 Apply rename x7 to tag 12 and a writeback on x7's old tag 9 in the same cycle -> x7 stays pending with tag 12 and its value is unchanged.
REQ-029 Apply rename x0 to tag 33, then a writeback on tag 33 with data 0x55 -> reads of x0 return 0 with valid=1.
REQ-030 Read x4 (pending, tag 20) in the same cycle as a writeback on tag 20 with data 0x1234 -> with WB_BYPASS_EN, 0x1234 with valid=1; without it, the old value with valid=0.

Source files
------------

// File: rtl/rename_reg_file.sv
// Rename register file: 32 architectural entries holding value, tag and pending flag.
// Optional macro WB_BYPASS_EN forwards same-cycle writebacks to reads and queries.
module rename_reg_file #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [TAG_W-1:0] q_rs_1,
    input  logic [TAG_W-1:0] q_rs_2,
    input  logic [TAG_W-1:0] q_rd,
    input  logic [TAG_W-1:0] q_new_tag,
    input  logic             q_rename,
    input  logic             q_tag,
    output logic [TAG_W-1:0] o_rs_1,
    output logic [TAG_W-1:0] o_rs_2,
    output logic [TAG_W-1:0] o_rd,
    output logic [TAG_W-1:0] o_new_tag,
    input  logic [TAG_W-1:0] v_src_1,
    input  logic [TAG_W-1:0] v_src_2,
    output logic [XLEN-1:0]  v_data_1,
    output logic [XLEN-1:0]  v_data_2,
    output logic             v_valid_1,
    output logic             v_valid_2,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [XLEN-1:0]  wb_data
);

    localparam int NENT = 32;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic [XLEN-1:0]  r_value [NENT];
    logic [TAG_W-1:0] r_tag   [NENT];
    logic [NENT-1:0]  r_pend;

    logic [NENT-1:0]  w_ren;
    logic [NENT-1:0]  w_wb;
    logic [XLEN-1:0]  w_d1;
    logic [XLEN-1:0]  w_d2;
    logic             w_v1;
    logic             w_v2;

    // Upper index bits only carry the tag-space MSB; the file is 32 deep.
    logic w_unused;
    assign w_unused = &{1'b0, q_rs_1[TAG_W-1:5], q_rs_2[TAG_W-1:5],
                        q_rd[TAG_W-1:5], v_src_1[TAG_W-1:5],
                        v_src_2[TAG_W-1:5]};

    // Per-entry rename and writeback hits; entry 0 never matches.
    always_comb begin
        w_ren = '0;
        w_wb  = '0;
        for (int i = 1; i < NENT; i++) begin
            w_ren[i] = q_rename && (q_rd[4:0] == 5'(i));
            w_wb[i]  = wb_valid && r_pend[i] && (r_tag[i] == wb_tag);
        end
    end

    // Tag a query reports for one index; byp lets a same-cycle writeback resolve it.
    function automatic logic [TAG_W-1:0] f_qtag(input logic [4:0] idx,
                                                input logic byp);
        logic [TAG_W-1:0] t;
        t = {{(TAG_W-5){1'b0}}, idx};
        if (r_pend[idx] && !(byp && w_wb[idx]))
            t = r_tag[idx];
        return t;
    endfunction

    // Value read mux with optional writeback forwarding.
    always_comb begin
        w_d1 = r_value[v_src_1[4:0]];
        w_v1 = !r_pend[v_src_1[4:0]];
        w_d2 = r_value[v_src_2[4:0]];
        w_v2 = !r_pend[v_src_2[4:0]];
        if (BYP && w_wb[v_src_1[4:0]]) begin
            w_d1 = wb_data;
            w_v1 = 1'b1;
        end
        if (BYP && w_wb[v_src_2[4:0]]) begin
            w_d2 = wb_data;
            w_v2 = 1'b1;
        end
    end

    // Entry state: rename beats a same-cycle writeback on the same entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NENT; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_pend <= '0;
        end else begin
            for (int i = 1; i < NENT; i++) begin
                if (w_ren[i]) begin
                    r_tag[i]  <= q_new_tag;
                    r_pend[i] <= 1'b1;
                end else if (w_wb[i]) begin
                    r_value[i] <= wb_data;
                    r_pend[i]  <= 1'b0;
                end
            end
        end
    end

    // Query outputs update only on a query strobe, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_rs_1    <= '0;
            o_rs_2    <= '0;
            o_rd      <= '0;
            o_new_tag <= '0;
        end else if (q_tag) begin
            o_rs_1    <= f_qtag(q_rs_1[4:0], BYP);
            o_rs_2    <= f_qtag(q_rs_2[4:0], BYP);
            o_rd      <= f_qtag(q_rd[4:0], 1'b0);
            o_new_tag <= q_new_tag;
        end
    end

    // Value read ports are registered every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_data_1  <= '0;
            v_data_2  <= '0;
            v_valid_1 <= 1'b0;
            v_valid_2 <= 1'b0;
        end else begin
            v_data_1  <= w_d1;
            v_data_2  <= w_d2;
            v_valid_1 <= w_v1;
            v_valid_2 <= w_v2;
        end
    end

endmodule

// File: tb/tb_rename_reg_file.sv
// Testbench for rename_reg_file: directed scenarios plus random traffic,
// checked by a queue-based scoreboard against an array model.
module tb_rename_reg_file;

    localparam int XLEN  = 32;
    localparam int TAG_W = 6;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [TAG_W-1:0] q_rs_1, q_rs_2, q_rd, q_new_tag;
    logic             q_rename, q_tag;
    logic [TAG_W-1:0] o_rs_1, o_rs_2, o_rd, o_new_tag;
    logic [TAG_W-1:0] v_src_1, v_src_2;
    logic [XLEN-1:0]  v_data_1, v_data_2;
    logic             v_valid_1, v_valid_2;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_data;

    rename_reg_file #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .q_rs_1(q_rs_1), .q_rs_2(q_rs_2), .q_rd(q_rd),
        .q_new_tag(q_new_tag), .q_rename(q_rename), .q_tag(q_tag),
        .o_rs_1(o_rs_1), .o_rs_2(o_rs_2), .o_rd(o_rd),
        .o_new_tag(o_new_tag),
        .v_src_1(v_src_1), .v_src_2(v_src_2),
        .v_data_1(v_data_1), .v_data_2(v_data_2),
        .v_valid_1(v_valid_1), .v_valid_2(v_valid_2),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] rs1, rs2, rd, nt;
        logic [XLEN-1:0]  d1, d2;
        logic             v1, v2;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference architectural state
    logic [XLEN-1:0]  m_val  [32];
    logic [TAG_W-1:0] m_tag  [32];
    logic             m_pend [32];
    exp_t             m_q;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic bit wb_hit(input int i);
        return wb_valid && m_pend[i] && (m_tag[i] == wb_tag);
    endfunction

    function automatic logic [TAG_W-1:0] ref_q(input logic [4:0] i,
                                               input bit src);
        if (m_pend[i] && !(src && BYP && wb_hit(int'(i))))
            return m_tag[i];
        return {1'b0, i};
    endfunction

    task automatic ref_rd(input logic [4:0] i, output logic [XLEN-1:0] d,
                          output logic v);
        if (i == 0) begin
            d = '0; v = 1'b1;
        end else if (BYP && wb_hit(int'(i))) begin
            d = wb_data; v = 1'b1;
        end else begin
            d = m_val[i]; v = !m_pend[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i] = '0; m_tag[i] = '0; m_pend[i] = 1'b0;
        end
        m_q = '{default: '0};
    endtask

    // Issue one cycle: predict outputs from pre-edge state, then advance the model.
    task automatic step();
        exp_t e;
        bit   hit [32];
        if (q_tag) begin
            m_q.rs1 = ref_q(q_rs_1[4:0], 1'b1);
            m_q.rs2 = ref_q(q_rs_2[4:0], 1'b1);
            m_q.rd  = ref_q(q_rd[4:0], 1'b0);
            m_q.nt  = q_new_tag;
        end
        e = m_q;
        ref_rd(v_src_1[4:0], e.d1, e.v1);
        ref_rd(v_src_2[4:0], e.d2, e.v2);
        sbq.push_back(e);
        for (int i = 0; i < 32; i++) hit[i] = wb_hit(i);
        for (int i = 1; i < 32; i++) begin
            if (q_rename && q_rd[4:0] == 5'(i)) begin
                m_tag[i] = q_new_tag; m_pend[i] = 1'b1;
            end else if (hit[i]) begin
                m_val[i] = wb_data; m_pend[i] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        q_rs_1 = '0; q_rs_2 = '0; q_rd = '0; q_new_tag = '0;
        q_rename = 1'b0; q_tag = 1'b0;
        v_src_1 = '0; v_src_2 = '0;
        wb_valid = 1'b0; wb_tag = '0; wb_data = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rs1"}, 64'(o_rs_1), 64'd0);
        chk({tag, "_rs2"}, 64'(o_rs_2), 64'd0);
        chk({tag, "_rd"},  64'(o_rd), 64'd0);
        chk({tag, "_nt"},  64'(o_new_tag), 64'd0);
        chk({tag, "_d1"},  64'(v_data_1), 64'd0);
        chk({tag, "_d2"},  64'(v_data_2), 64'd0);
        chk({tag, "_v1"},  64'(v_valid_1), 64'd0);
        chk({tag, "_v2"},  64'(v_valid_2), 64'd0);
    endtask

    // Asynchronous reset pulse between clock edges
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk_zero({tag, "_async"});
        model_reset();
        @(posedge clk); #1;
        chk_zero({tag, "_held"});
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every post-edge sample is compared with the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("o_rs_1",    64'(o_rs_1),    64'(e.rs1));
                chk("o_rs_2",    64'(o_rs_2),    64'(e.rs2));
                chk("o_rd",      64'(o_rd),      64'(e.rd));
                chk("o_new_tag", 64'(o_new_tag), 64'(e.nt));
                chk("v_data_1",  64'(v_data_1),  64'(e.d1));
                chk("v_data_2",  64'(v_data_2),  64'(e.d2));
                chk("v_valid_1", 64'(v_valid_1), 64'(e.v1));
                chk("v_valid_2", 64'(v_valid_2), 64'(e.v2));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic rand_cycle();
        q_rs_1    = TAG_W'($urandom);
        q_rs_2    = TAG_W'($urandom);
        q_rd      = TAG_W'($urandom);
        q_new_tag = TAG_W'($urandom);
        q_rename  = ($urandom_range(9) < 4);
        q_tag     = ($urandom_range(9) < 7);
        v_src_1   = TAG_W'($urandom);
        v_src_2   = TAG_W'($urandom);
        wb_valid  = ($urandom_range(1) == 1);
        if ($urandom_range(9) < 7)
            wb_tag = m_tag[$urandom_range(31)];
        else
            wb_tag = TAG_W'($urandom);
        wb_data   = $urandom;
        step();
    endtask

    initial begin
        idle();
        model_reset();
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Reads right after reset
        idle(); v_src_1 = 6'd5; v_src_2 = 6'd0; step();
        // Rename x3 -> 40 then query and read it
        idle(); q_rename = 1'b1; q_rd = 6'd3; q_new_tag = 6'd40; step();
        idle(); q_tag = 1'b1; q_rs_1 = 6'd3; q_rd = 6'd3; v_src_1 = 6'd3; step();
        // Writeback resolves x3
        idle(); wb_valid = 1'b1; wb_tag = 6'd40; wb_data = 32'hDEADBEEF;
        v_src_1 = 6'd3; step();
        idle(); q_tag = 1'b1; q_rs_1 = 6'd3; v_src_1 = 6'd3; step();
        // Rename and old-tag writeback collide on x7
        idle(); q_rename = 1'b1; q_rd = 6'd7; q_new_tag = 6'd9; step();
        idle(); q_rename = 1'b1; q_rd = 6'd7; q_new_tag = 6'd12;
        wb_valid = 1'b1; wb_tag = 6'd9; wb_data = 32'h0000AAAA; step();
        idle(); q_tag = 1'b1; q_rs_1 = 6'd7; q_rd = 6'd7; v_src_1 = 6'd7; step();
        // Writes to x0 are ignored
        idle(); q_rename = 1'b1; q_rd = 6'd0; q_new_tag = 6'd33; step();
        idle(); wb_valid = 1'b1; wb_tag = 6'd33; wb_data = 32'h55; step();
        idle(); q_tag = 1'b1; q_rs_1 = 6'd0; q_rd = 6'd32; step();
        // Same-cycle read of x4 during its writeback
        idle(); q_rename = 1'b1; q_rd = 6'd4; q_new_tag = 6'd20; step();
        idle(); wb_valid = 1'b1; wb_tag = 6'd20; wb_data = 32'h777; step();
        idle(); q_rename = 1'b1; q_rd = 6'd4; q_new_tag = 6'd20; step();
        idle(); v_src_1 = 6'd4; q_tag = 1'b1; q_rs_2 = 6'd4;
        wb_valid = 1'b1; wb_tag = 6'd20; wb_data = 32'h1234; step();
        idle(); v_src_2 = 6'd4; step();

        for (int n = 0; n < 300; n++) rand_cycle();
        idle();
        do_reset("midreset");
        idle(); v_src_1 = 6'd9; v_src_2 = 6'd31; q_tag = 1'b1;
        q_rs_1 = 6'd12; step();
        for (int n = 0; n < 300; n++) rand_cycle();
        idle(); step();
        @(negedge clk);
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, required 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
